scan_test_ctrl: RTL and testbench

SCAN_TEST_CTRL -- requirements
Module: scan_test_ctrl

---
 rtl/scan_test_ctrl_if.sv | 22 ++
 rtl/scan_test_ctrl.sv | 117 +++++++++++
 tb/tb_scan_test_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/scan_test_ctrl_if.sv
// Scan test controller bus: run control, chain drive/observe, and status.
// master = controller side, slave = host/chain side.
interface scan_test_ctrl_if;
    logic        START;
    logic        SO;
    logic        SSEL;
    logic        SDIN;
    logic        BUSY;
    logic        DONE;
    logic [15:0] SIGNATURE;
    logic [9:0]  PAT_CNT;

    modport master (
        input  START, SO,
        output SSEL, SDIN, BUSY, DONE, SIGNATURE, PAT_CNT
    );

    modport slave (
        output START, SO,
        input  SSEL, SDIN, BUSY, DONE, SIGNATURE, PAT_CNT
    );
endinterface

// File: rtl/scan_test_ctrl.sv
// Scan BIST controller: loads LFSR patterns into a scan chain, pulses one
// functional capture per pattern, and compacts the shifted-out responses
// into a 16-bit MISR signature. All outputs come straight from flops.
module scan_test_ctrl #(
    parameter int          CHAIN_LEN    = 74,
    parameter int          NUM_PATTERNS = 16,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic              CLK,
    input  logic              RST,
    scan_test_ctrl_if.master  bus
);
    localparam int             CW   = $clog2(CHAIN_LEN);
    localparam logic [CW-1:0]  LAST = CW'(CHAIN_LEN - 1);
    localparam logic [9:0]     NPAT = 10'(NUM_PATTERNS);

    typedef enum logic [2:0] {
        S_IDLE, S_SHIFT, S_CAPTURE, S_UNLOAD, S_DONE
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [15:0]     r_lfsr;
    logic [15:0]     r_misr;
    logic [9:0]      r_pat;
    logic            r_ssel;
    logic            r_sdin;
    logic            r_busy;
    logic            r_done;

    logic [15:0]     w_lfsr_nxt;
    logic [15:0]     w_misr_nxt;
    logic [9:0]      w_pat_inc;
    logic            w_last;

    assign w_lfsr_nxt = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    assign w_misr_nxt = {r_misr[14:0], r_misr[15] ^ r_misr[13] ^ r_misr[12] ^ r_misr[10] ^ bus.SO};
    assign w_pat_inc  = r_pat + 10'd1;
    assign w_last     = (r_cnt == LAST);

    // Sequencer: r_sdin always holds the bit for the cycle being entered, so
    // during SHIFT it tracks the LFSR value that is about to be consumed.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_lfsr  <= SEED;
            r_misr  <= '0;
            r_pat   <= '0;
            r_ssel  <= 1'b0;
            r_sdin  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.START) begin
                        r_state <= S_SHIFT;
                        r_cnt   <= '0;
                        r_lfsr  <= SEED;
                        r_misr  <= '0;
                        r_pat   <= '0;
                        r_ssel  <= 1'b1;
                        r_sdin  <= SEED[0];
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    // The first load pushes out power-up junk, not a response.
                    if (r_pat != 10'd0) r_misr <= w_misr_nxt;
                    r_lfsr <= w_lfsr_nxt;
                    if (w_last) begin
                        r_state <= S_CAPTURE;
                        r_cnt   <= '0;
                        r_ssel  <= 1'b0;
                        r_sdin  <= 1'b0;
                    end else begin
                        r_cnt  <= r_cnt + CW'(1);
                        r_sdin <= w_lfsr_nxt[0];
                    end
                end
                S_CAPTURE: begin
                    r_pat  <= w_pat_inc;
                    r_ssel <= 1'b1;
                    if (w_pat_inc < NPAT) begin
                        r_state <= S_SHIFT;
                        r_sdin  <= r_lfsr[0];
                    end else begin
                        r_state <= S_UNLOAD;
                        r_sdin  <= 1'b0;
                    end
                end
                S_UNLOAD: begin
                    r_misr <= w_misr_nxt;
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_cnt   <= '0;
                        r_ssel  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.SSEL      = r_ssel;
    assign bus.SDIN      = r_sdin;
    assign bus.BUSY      = r_busy;
    assign bus.DONE      = r_done;
    assign bus.SIGNATURE = r_misr;
    assign bus.PAT_CNT   = r_pat;
endmodule

// File: tb/tb_scan_test_ctrl.sv
// Bench for scan_test_ctrl: a behavioural scan chain with random functional
// logic sits on the bus; expected signatures are built pattern-by-pattern.
module tb_scan_test_ctrl;
    localparam int          L       = 4;
    localparam int          N       = 3;
    localparam logic [15:0] SEED    = 16'hACE1;
    localparam int          RUN_CYC = N * (L + 1) + L;
    localparam int          BUDGET  = RUN_CYC + 40;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   checks = 0;
    int   errors = 0;

    scan_test_ctrl_if sif();

    scan_test_ctrl #(.CHAIN_LEN(L), .NUM_PATTERNS(N), .SEED(SEED)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (sif.master)
    );

    always #5 CLK = ~CLK;

    int         so_mode  = 0;   // 0 chain, 1 tie 0, 2 tie 1, 3 random
    logic       so_rnd   = 1'b0;
    logic [L-1:0] mask   = '0;
    bit         fault_en = 1'b0;
    int         fcell    = 0;
    logic [L-1:0] chain  = '0;
    logic       so_log   [BUDGET];
    logic       sdin_log [BUDGET];

    // Functional logic of the circuit under test, with optional stuck-at-0 cell input.
    function automatic logic [L-1:0] cut(input logic [L-1:0] v, input logic [L-1:0] m,
                                         input bit fe, input int fc);
        logic [L-1:0] c;
        for (int i = 0; i < L; i++) c[i] = v[i] ^ (v[(i+1)%L] & v[(i+2)%L]) ^ m[i];
        if (fe) c[fc] = 1'b0;
        return c;
    endfunction

    // Scan chain of mux-D cells: cell 0 fed by SDIN, SO from the last cell.
    always @(posedge CLK) chain <= sif.SSEL ? {chain[L-2:0], sif.SDIN} : cut(chain, mask, fault_en, fcell);

    assign sif.SO = (so_mode == 0) ? chain[L-1] :
                    (so_mode == 1) ? 1'b0 :
                    (so_mode == 2) ? 1'b1 : so_rnd;

    function automatic logic lfsr_bit(input int k);
        logic [15:0] lf = SEED;
        for (int i = 0; i < k; i++) lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
        return lf[0];
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] m, input logic b);
        return {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10] ^ b};
    endfunction

    // Expected signature: every pattern's response is unloaded MSB cell first.
    function automatic logic [15:0] model_sig(input int mode);
        logic [15:0]  m = '0;
        logic [L-1:0] v;
        logic [L-1:0] c;
        logic         b;
        if (mode == 3) begin
            for (int t = 0; t < RUN_CYC; t++)
                if (t >= N * (L + 1) || (t / (L + 1) > 0 && t % (L + 1) < L))
                    m = misr_step(m, so_log[t]);
        end else begin
            for (int p = 0; p < N; p++) begin
                for (int i = 0; i < L; i++) v[i] = lfsr_bit(p * L + L - 1 - i);
                c = cut(v, mask, fault_en, fcell);
                for (int k = 0; k < L; k++) begin
                    b = (mode == 0) ? c[L-1-k] : (mode == 2);
                    m = misr_step(m, b);
                end
            end
        end
        return m;
    endfunction

    function automatic logic exp_ssel(input int t);
        return (t >= N * (L + 1)) || (t % (L + 1) < L);
    endfunction

    function automatic logic exp_sdin(input int t);
        if (t < N * (L + 1) && t % (L + 1) < L) return lfsr_bit((t / (L + 1)) * L + t % (L + 1));
        return 1'b0;
    endfunction

    function automatic int exp_pat(input int t);
        return (t < N * (L + 1)) ? t / (L + 1) : N;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ne(input string tag, input logic [31:0] obs, input logic [31:0] unexp);
        checks++;
        assert (obs !== unexp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected anything but %0h", tag, obs, unexp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ssel"}, sif.SSEL, 0);
        chk({tag, "_sdin"}, sif.SDIN, 0);
        chk({tag, "_busy"}, sif.BUSY, 0);
        chk({tag, "_done"}, sif.DONE, 0);
        chk({tag, "_sig"},  sif.SIGNATURE, 0);
        chk({tag, "_pat"},  sif.PAT_CNT, 0);
    endtask

    // One run, sampled at negedges; t=0 is the first SHIFT cycle.
    task automatic run(input bit pulse, input bit hold, output logic [15:0] sig);
        int dcyc = -1;
        if (pulse) begin
            sif.START = 1'b1;
            @(negedge CLK);
        end
        sif.START = hold;
        for (int t = 0; t < BUDGET; t++) begin
            if (sif.DONE) begin
                dcyc = t;
                break;
            end
            sdin_log[t] = sif.SDIN;
            if (t < RUN_CYC) begin
                chk("ssel", sif.SSEL, exp_ssel(t));
                chk("sdin", sif.SDIN, exp_sdin(t));
                chk("busy", sif.BUSY, 1);
                chk("pat",  sif.PAT_CNT, exp_pat(t));
            end
            so_rnd    = 1'($urandom_range(0, 1));
            so_log[t] = so_rnd;
            @(negedge CLK);
        end
        chk("done_cycle", dcyc, RUN_CYC);
        chk("done_pat",   sif.PAT_CNT, N);
        chk("done_busy",  sif.BUSY, 0);
        chk("done_ssel",  sif.SSEL, 0);
        sig = sif.SIGNATURE;
    endtask

    logic [15:0] sig_a, sig_b, sig_c, sig_x, good;
    int          k;

    initial begin
        sif.START = 1'b0;
        #1 RST = 1'b1;
        #2 chk_reset("por");
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge CLK);
        chk("idle_busy", sif.BUSY, 0);

        // Chain run with random functional logic; seed gives four leading ones.
        mask = L'($urandom);
        run(1'b1, 1'b0, sig_a);
        good = model_sig(0);
        chk("sig_a", sig_a, good);
        if (good != 16'h0) chk_ne("sig_a_nonzero", sig_a, 0);
        for (int i = 0; i < 4; i++) chk("seed_sdin", sdin_log[i], 1);

        // DONE holds status until a new START.
        repeat ($urandom_range(3, 8)) begin
            @(negedge CLK);
            chk("hold_done", sif.DONE, 1);
            chk("hold_sig",  sif.SIGNATURE, good);
            chk("hold_pat",  sif.PAT_CNT, N);
        end

        // Second run must reproduce the signature.
        run(1'b1, 1'b0, sig_b);
        chk("sig_b", sig_b, good);

        // Stuck-at-0 on one cell's capture input.
        fault_en = 1'b1;
        fcell    = int'($urandom_range(0, L - 1));
        run(1'b1, 1'b0, sig_c);
        chk("sig_fault", sig_c, model_sig(0));
        if (model_sig(0) != good) chk_ne("fault_changes_sig", sig_c, good);
        fault_en = 1'b0;

        // Tied and random scan-out streams.
        so_mode = 1;
        run(1'b1, 1'b0, sig_x);
        chk("sig_tie0", sig_x, 0);
        so_mode = 2;
        run(1'b1, 1'b0, sig_x);
        chk("sig_tie1", sig_x, model_sig(2));
        so_mode = 3;
        run(1'b1, 1'b0, sig_x);
        chk("sig_rand", sig_x, model_sig(3));
        so_mode = 0;

        // Asynchronous reset in the middle of the third pattern's load.
        k = int'($urandom_range(0, L - 1));
        sif.START = 1'b1;
        @(negedge CLK);
        sif.START = 1'b0;
        repeat (2 * (L + 1) + k) @(negedge CLK);
        chk("mid_busy", sif.BUSY, 1);
        #2 RST = 1'b1;
        #1 chk_reset("mid_rst");
        @(negedge CLK);
        chk_reset("mid_hold");
        RST = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            chk_reset("post_rst_idle");
        end
        run(1'b1, 1'b0, sig_x);
        chk("sig_after_rst", sig_x, good);

        // START held through the run and into DONE restarts from DONE.
        run(1'b1, 1'b1, sig_x);
        chk("sig_held", sig_x, good);
        @(negedge CLK);
        chk("restart_busy", sif.BUSY, 1);
        chk("restart_done", sif.DONE, 0);
        chk("restart_sig",  sif.SIGNATURE, 0);
        chk("restart_pat",  sif.PAT_CNT, 0);
        run(1'b0, 1'b0, sig_x);
        chk("sig_restart", sig_x, good);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
